// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: host-side and device-side req/gnt/rvalid bundle
// plus region config for the round-robin bus interconnect.
interface bus_rr_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [NrHosts-1:0]                      host_req_i;
  logic [NrHosts-1:0]                      host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i;
  logic [NrHosts-1:0]                      host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i;
  logic [NrHosts-1:0]                      host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o;
  logic [NrHosts-1:0]                      host_err_o;

  logic [NrDevices-1:0]                    device_req_o;
  logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o;
  logic [NrDevices-1:0]                    device_we_o;
  logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o;
  logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o;
  logic [NrDevices-1:0]                    device_rvalid_i;
  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i;
  logic [NrDevices-1:0]                    device_err_i;

  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base;
  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i,
    input  host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o,
    output host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o,
    output device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i,
    input  device_err_i,
    input  cfg_device_addr_base, cfg_device_addr_mask
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i,
    output host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o,
    input  host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o,
    input  device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i,
    output device_err_i,
    output cfg_device_addr_base, cfg_device_addr_mask
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin multi-host to multi-device interconnect
// with in-order response tracking and internal decode-error responses.
module bus_rr_arbiter #(
  parameter int NrHosts        = 2,
  parameter int NrDevices      = 3,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bus_rr_arbiter_if.slave bus
);
  localparam int HostW =
    (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevW =
    (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int PtrW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [HostW-1:0] host;
    logic [DevW-1:0]  dev;
    logic             miss;
  } entry_t;

  entry_t           fifo_q [MaxOutstanding];
  entry_t           fifo_d [MaxOutstanding];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HostW-1:0] rr_q, rr_d;
  logic [DevW-1:0]  last_dev_q, last_dev_d;
  logic             fresh_q, fresh_d;

  logic             cand_vld;
  logic [HostW-1:0] cand;
  logic [AddressWidth-1:0] cand_addr;
  logic             cand_hit;
  logic [DevW-1:0]  cand_dev;

  entry_t           head;
  logic             head_vld;
  logic             pop;
  logic             push;
  logic             accept;
  logic             dev_ok;
  logic [CntW-1:0]  cnt_post;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(MaxOutstanding - 1)) ?
      '0 : p + 1'b1;
  endfunction

  always_comb begin
    int idx;
    logic [HostW-1:0] h;
    idx      = 0;
    h        = '0;
    cand_vld = 1'b0;
    cand     = '0;
    // Walk downwards so the host nearest rr_q wins.
    for (int i = NrHosts - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NrHosts) idx = idx - NrHosts;
      h = HostW'(idx);
      if (bus.host_req_i[h]) begin
        cand_vld = 1'b1;
        cand     = h;
      end
    end
  end

  always_comb begin
    cand_addr = bus.host_addr_i[cand];
    cand_hit  = 1'b0;
    cand_dev  = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((cand_addr & bus.cfg_device_addr_mask[d])
          == bus.cfg_device_addr_base[d]) begin
        cand_hit = 1'b1;
        cand_dev = DevW'(d);
      end
    end
  end

  always_comb begin
    head     = fifo_q[rd_ptr_q];
    head_vld = (cnt_q != '0);
    pop      = head_vld &
               (head.miss | bus.device_rvalid_i[head.dev]);
    cnt_post = cnt_q - CntW'(pop);
    // Outstanding hits all target last_dev, so matching it
    // keeps device responses in grant order.
    dev_ok   = (cnt_post == '0) | ~cand_hit |
               (cand_dev == last_dev_q);
    accept   = rst_ni & cand_vld & dev_ok &
               (cnt_post != CntW'(MaxOutstanding));
    push     = accept;
  end

  always_comb begin
    bus.host_gnt_o     = '0;
    bus.host_rvalid_o  = '0;
    bus.host_rdata_o   = '0;
    bus.host_err_o     = '0;
    bus.device_req_o   = '0;
    bus.device_addr_o  = '0;
    bus.device_we_o    = '0;
    bus.device_be_o    = '0;
    bus.device_wdata_o = '0;
    if (accept) begin
      bus.host_gnt_o[cand] = 1'b1;
      if (cand_hit) begin
        bus.device_req_o[cand_dev]   = 1'b1;
        bus.device_addr_o[cand_dev]  =
          bus.host_addr_i[cand];
        bus.device_we_o[cand_dev]    =
          bus.host_we_i[cand];
        bus.device_be_o[cand_dev]    =
          bus.host_be_i[cand];
        bus.device_wdata_o[cand_dev] =
          bus.host_wdata_i[cand];
      end
    end
    if (pop) begin
      bus.host_rvalid_o[head.host] = 1'b1;
      if (head.miss) begin
        bus.host_err_o[head.host] = 1'b1;
      end else begin
        bus.host_rdata_o[head.host] =
          bus.device_rdata_i[head.dev];
        bus.host_err_o[head.host]   =
          bus.device_err_i[head.dev];
      end
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_post + CntW'(push);
    rr_d       = rr_q;
    last_dev_d = last_dev_q;
    fresh_d    = fresh_q & ~push;
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) begin
      fifo_d[wr_ptr_q] = '{
        host: cand,
        dev:  cand_dev,
        miss: ~cand_hit
      };
      wr_ptr_d = ptr_inc(wr_ptr_q);
      rr_d     = (cand == HostW'(NrHosts - 1)) ?
                 '0 : cand + 1'b1;
      if (cand_hit) last_dev_d = cand_dev;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      last_dev_q <= '0;
      fresh_q    <= 1'b1;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      last_dev_q <= last_dev_d;
      fresh_q    <= fresh_d;
    end
  end

  logic [NrDevices-1:0] rsp_ok;

  always_comb begin
    rsp_ok = '0;
    if (head_vld && !head.miss) rsp_ok[head.dev] = 1'b1;
  end

  // Late responses to transactions dropped by a reset may
  // still arrive before the first new grant; tolerate those.
  stray_rvalid: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    fresh_q || ((bus.device_rvalid_i & ~rsp_ok) == '0)
  );
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed scenarios with literal expectations and a
// queue-based reference model compared on every falling edge.
module tb_bus_rr_arbiter;
  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   rv0 = 0;
  int   rv1 = 0;

  bus_rr_arbiter_if #(
    .NrHosts(NH), .NrDevices(ND),
    .DataWidth(DW), .AddressWidth(AW)
  ) bus ();

  bus_rr_arbiter #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(DW),
    .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++)
      if ((a & bus.cfg_device_addr_mask[d]) ==
          bus.cfg_device_addr_base[d]) return d;
    return -1;
  endfunction

  typedef struct {
    int host;
    int dev;
    bit miss;
  } ent_t;

  ent_t mq[$];
  int   m_rr = 0;
  int   m_last = 0;
  bit   n_pop = 0;
  bit   n_acc = 0;
  int   n_cand = -1;
  int   n_dev = -1;

  always @(negedge clk) begin : model_cmp
    logic [NH-1:0]         e_gnt, e_rv, e_err;
    logic [NH-1:0][DW-1:0] e_rd;
    logic [ND-1:0]         e_req, e_we;
    logic [ND-1:0][AW-1:0] e_addr;
    logic [ND-1:0][DW/8-1:0] e_be;
    logic [ND-1:0][DW-1:0] e_wd;
    int post;
    if (!rst_n) begin
      mq.delete();
      m_rr = 0;
      m_last = 0;
    end
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0;
    e_req = '0; e_we = '0; e_addr = '0; e_be = '0; e_wd = '0;
    n_pop = 0;
    if (rst_n && mq.size() > 0)
      n_pop = mq[0].miss ? 1'b1 :
              (bus.device_rvalid_i[mq[0].dev] === 1'b1);
    post = mq.size() - (n_pop ? 1 : 0);
    n_cand = -1;
    for (int i = 0; i < NH; i++)
      if (n_cand < 0 && bus.host_req_i[(m_rr + i) % NH])
        n_cand = (m_rr + i) % NH;
    n_dev = (n_cand >= 0) ? decode(bus.host_addr_i[n_cand]) : -1;
    n_acc = rst_n && n_cand >= 0 && post < MO &&
            (post == 0 || n_dev < 0 || n_dev == m_last);
    if (n_acc) begin
      e_gnt[n_cand] = 1'b1;
      if (n_dev >= 0) begin
        e_req[n_dev]  = 1'b1;
        e_addr[n_dev] = bus.host_addr_i[n_cand];
        e_we[n_dev]   = bus.host_we_i[n_cand];
        e_be[n_dev]   = bus.host_be_i[n_cand];
        e_wd[n_dev]   = bus.host_wdata_i[n_cand];
      end
    end
    if (n_pop) begin
      e_rv[mq[0].host] = 1'b1;
      if (mq[0].miss) begin
        e_err[mq[0].host] = 1'b1;
      end else begin
        e_rd[mq[0].host]  = bus.device_rdata_i[mq[0].dev];
        e_err[mq[0].host] = bus.device_err_i[mq[0].dev];
      end
    end
    chk("m_gnt", 256'(bus.host_gnt_o), 256'(e_gnt));
    chk("m_rvalid", 256'(bus.host_rvalid_o), 256'(e_rv));
    chk("m_err", 256'(bus.host_err_o), 256'(e_err));
    chk("m_rdata", 256'(bus.host_rdata_o), 256'(e_rd));
    chk("m_dreq", 256'(bus.device_req_o), 256'(e_req));
    chk("m_daddr", 256'(bus.device_addr_o), 256'(e_addr));
    chk("m_dwe", 256'(bus.device_we_o), 256'(e_we));
    chk("m_dbe", 256'(bus.device_be_o), 256'(e_be));
    chk("m_dwdata", 256'(bus.device_wdata_o), 256'(e_wd));
  end

  always @(posedge clk) begin : model_upd
    if (!rst_n) begin
      mq.delete();
      m_rr = 0;
      m_last = 0;
    end else begin
      if (n_pop) void'(mq.pop_front());
      if (n_acc) begin
        mq.push_back('{host: n_cand, dev: n_dev, miss: (n_dev < 0)});
        m_rr = (n_cand + 1) % NH;
        if (n_dev >= 0) m_last = n_dev;
      end
    end
    n_pop = 0;
    n_acc = 0;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.host_req_i      = '0;
    bus.device_rvalid_i = '0;
    bus.device_rdata_i  = '0;
    bus.device_err_i    = '0;
  endtask

  task automatic hreq(input int h, input logic [AW-1:0] a,
                      input logic we);
    bus.host_req_i[h]   = 1'b1;
    bus.host_addr_i[h]  = a;
    bus.host_we_i[h]    = we;
    bus.host_be_i[h]    = we ? 4'h3 : 4'hF;
    bus.host_wdata_i[h] = 32'hD00D_0000 | {16'h0, a[15:0]};
  endtask

  task automatic drsp(input int d, input logic [DW-1:0] data,
                      input logic err);
    bus.device_rvalid_i[d] = 1'b1;
    bus.device_rdata_i[d]  = data;
    bus.device_err_i[d]    = err;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.host_addr_i  = '0;
    bus.host_we_i    = '0;
    bus.host_be_i    = '0;
    bus.host_wdata_i = '0;
    idle();
    bus.cfg_device_addr_base[0] = 32'h0010_0000;
    bus.cfg_device_addr_mask[0] = 32'hFFF0_0000;
    bus.cfg_device_addr_base[1] = 32'h0002_0000;
    bus.cfg_device_addr_mask[1] = 32'hFFFF_FC00;
    bus.cfg_device_addr_base[2] = 32'h0003_0000;
    bus.cfg_device_addr_mask[2] = 32'hFFFF_FC00;
    hreq(0, 32'h0010_0000, 1'b0);

    // reset: requests present but nothing granted or driven
    repeat (2) @(posedge clk);
    mid();
    chk("rst_gnt", 256'(bus.host_gnt_o), 256'(2'b00));
    chk("rst_rvalid", 256'(bus.host_rvalid_o), 256'(2'b00));
    chk("rst_dreq", 256'(bus.device_req_o), 256'(3'b000));
    chk("rst_rdata", 256'(bus.host_rdata_o), 256'(64'h0));
    nxt(); rst_n = 1'b1; idle();

    // 1: single host read from RAM, 1-cycle device
    nxt(); idle(); hreq(1, 32'h0010_0010, 1'b0);
    mid();
    chk("t1_gnt", 256'(bus.host_gnt_o), 256'(2'b10));
    chk("t1_dreq", 256'(bus.device_req_o), 256'(3'b001));
    chk("t1_daddr", 256'(bus.device_addr_o[0]),
        256'(32'h0010_0010));
    nxt(); idle(); drsp(0, 32'hCAFE_0001, 1'b0);
    mid();
    chk("t1_rvalid", 256'(bus.host_rvalid_o), 256'(2'b10));
    chk("t1_rdata", 256'(bus.host_rdata_o[1]), 256'(32'hCAFE_0001));
    chk("t1_err", 256'(bus.host_err_o), 256'(2'b00));

    // 2: both hosts stream to the Timer
    for (int k = 0; k < 5; k++) begin
      nxt(); idle();
      if (k < 4) begin
        hreq(0, 32'h0003_0000, 1'b0);
        hreq(1, 32'h0003_0004, 1'b1);
      end
      if (k > 0) drsp(2, 32'h7000_0000 + k, 1'b0);
      mid();
      chk("t2_gnt", 256'(bus.host_gnt_o),
          256'((k == 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10)));
      chk("t2_rvalid", 256'(bus.host_rvalid_o),
          256'((k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10)));
      rv0 += int'(bus.host_rvalid_o[0]);
      rv1 += int'(bus.host_rvalid_o[1]);
    end
    chk("t2_cnt0", 256'(rv0), 256'(2));
    chk("t2_cnt1", 256'(rv1), 256'(2));

    // 3: decode miss
    nxt(); idle(); hreq(0, 32'h0000_0000, 1'b0);
    mid();
    chk("t3_gnt", 256'(bus.host_gnt_o), 256'(2'b01));
    chk("t3_dreq", 256'(bus.device_req_o), 256'(3'b000));
    nxt(); idle();
    mid();
    chk("t3_rvalid", 256'(bus.host_rvalid_o), 256'(2'b01));
    chk("t3_err", 256'(bus.host_err_o), 256'(2'b01));
    chk("t3_rdata", 256'(bus.host_rdata_o[0]), 256'(32'h0));

    // 4: slow RAM then SimCtrl waits for drain
    nxt(); idle(); hreq(0, 32'h0010_0020, 1'b0);
    mid();
    chk("t4_gnt0", 256'(bus.host_gnt_o), 256'(2'b01));
    for (int k = 0; k < 2; k++) begin
      nxt(); idle(); hreq(1, 32'h0002_0004, 1'b1);
      mid();
      chk("t4_hold_gnt", 256'(bus.host_gnt_o), 256'(2'b00));
      chk("t4_hold_dreq", 256'(bus.device_req_o), 256'(3'b000));
    end
    nxt(); idle(); hreq(1, 32'h0002_0004, 1'b1);
    drsp(0, 32'hBEEF_0004, 1'b0);
    mid();
    chk("t4_gnt1", 256'(bus.host_gnt_o), 256'(2'b10));
    chk("t4_dreq", 256'(bus.device_req_o), 256'(3'b010));
    chk("t4_dwe", 256'(bus.device_we_o), 256'(3'b010));
    chk("t4_rv0", 256'(bus.host_rvalid_o), 256'(2'b01));
    chk("t4_rdata0", 256'(bus.host_rdata_o[0]), 256'(32'hBEEF_0004));
    nxt(); idle(); drsp(1, 32'h5100_0001, 1'b0);
    mid();
    chk("t4_rv1", 256'(bus.host_rvalid_o), 256'(2'b10));

    // 5: FIFO full on a stalled device
    nxt(); idle(); hreq(0, 32'h0010_0100, 1'b0);
    mid();
    chk("t5_g1", 256'(bus.host_gnt_o), 256'(2'b01));
    nxt(); idle(); hreq(0, 32'h0010_0104, 1'b0);
    mid();
    chk("t5_g2", 256'(bus.host_gnt_o), 256'(2'b01));
    for (int k = 0; k < 2; k++) begin
      nxt(); idle(); hreq(0, 32'h0010_0108, 1'b0);
      mid();
      chk("t5_full", 256'(bus.host_gnt_o), 256'(2'b00));
    end
    nxt(); idle(); hreq(0, 32'h0010_0108, 1'b0);
    drsp(0, 32'h1111_0000, 1'b0);
    mid();
    chk("t5_g3", 256'(bus.host_gnt_o), 256'(2'b01));
    chk("t5_rv1", 256'(bus.host_rvalid_o), 256'(2'b01));
    chk("t5_rd1", 256'(bus.host_rdata_o[0]), 256'(32'h1111_0000));
    nxt(); idle(); drsp(0, 32'h2222_0000, 1'b0);
    mid();
    chk("t5_rv2", 256'(bus.host_rvalid_o), 256'(2'b01));
    nxt(); idle(); drsp(0, 32'h3333_0000, 1'b1);
    mid();
    chk("t5_rv3", 256'(bus.host_rvalid_o), 256'(2'b01));
    chk("t5_err3", 256'(bus.host_err_o), 256'(2'b01));

    // 6: reset with two outstanding
    nxt(); idle();
    hreq(0, 32'h0010_0200, 1'b0);
    hreq(1, 32'h0010_0204, 1'b0);
    mid();
    chk("t6_g1", 256'(bus.host_gnt_o), 256'(2'b10));
    nxt(); idle(); hreq(0, 32'h0010_0200, 1'b0);
    mid();
    chk("t6_g0", 256'(bus.host_gnt_o), 256'(2'b01));
    nxt(); idle(); hreq(0, 32'h0010_0208, 1'b0);
    drsp(0, 32'h4444_0000, 1'b0);
    #1;
    chk("t6_pre_gnt", 256'(bus.host_gnt_o), 256'(2'b01));
    chk("t6_pre_rv", 256'(bus.host_rvalid_o), 256'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 256'(bus.host_gnt_o), 256'(2'b00));
    chk("t6_rst_rv", 256'(bus.host_rvalid_o), 256'(2'b00));
    chk("t6_rst_dreq", 256'(bus.device_req_o), 256'(3'b000));
    chk("t6_rst_rdata", 256'(bus.host_rdata_o), 256'(64'h0));
    chk("t6_rst_err", 256'(bus.host_err_o), 256'(2'b00));
    mid();
    nxt(); rst_n = 1'b1; idle();
    drsp(0, 32'h5555_0000, 1'b0);
    mid();
    chk("t6_late_rv", 256'(bus.host_rvalid_o), 256'(2'b00));
    chk("t6_late_rdata", 256'(bus.host_rdata_o), 256'(64'h0));
    nxt(); idle();
    repeat (2) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
